// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and helpers for the I2S master transmitter.
//   state_e    : transmitter FSM states (IDLE, RUN, DRAIN)
//   frame_bits : BCLK periods per stereo frame (two channel slots)
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned slot_bits);
    return 2 * slot_bits;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to the I2S bit clock.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   run_i  : 1 = divider running; 0 = divider cleared and bclk held low
//   bclk_o : bit clock, toggles every BCLK_HALF clk cycles while running
//   fall_o : strobe, high in the clk cycle whose edge drives bclk 1->0
module i2s_bclk_gen #(
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  assign wrap = (div_q == DIV_LAST);

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = run_i && wrap && bclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S bus master and stereo transmitter.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   enable       : run request
//   sample_L/R   : stereo sample pair, two's complement
//   sample_valid : pair offered
//   sample_ready : one-deep buffer empty; pair taken on valid && ready
//   i2s_bclk     : bit clock (outputs change only on its falling edge)
//   i2s_lrck     : word select, 0 = left, 1 = right
//   i2s_dat      : serial data, MSB first, one BCLK after the lrck change
//   frame_start  : one-clk pulse at each frame load
//   underrun     : one-clk pulse when a frame loads with the buffer empty
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned BCLK_HALF   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WORD_LENGTH-1:0] sample_L,
  input  logic [WORD_LENGTH-1:0] sample_R,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_dat,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int unsigned   FRAME_BITS = frame_bits(SLOT_BITS);
  localparam int unsigned   BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] CNT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT       = BW'(SLOT_BITS);
  localparam logic [BW-1:0] WLEN       = BW'(WORD_LENGTH);

  state_e                 state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   lrck_q, lrck_d;
  logic                   dat_q, dat_d;
  logic [WORD_LENGTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                   buf_full_q, buf_full_d;
  logic [WORD_LENGTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;

  logic          fall, wrap, accept, in_right;
  logic [BW-1:0] cnt_next, pos;

  i2s_bclk_gen #(
    .BCLK_HALF(BCLK_HALF)
  ) u_bclk (
    .clk   (clk),
    .rst_n (reset),
    .run_i (state_q != IDLE),
    .bclk_o(i2s_bclk),
    .fall_o(fall)
  );

  assign accept   = sample_valid && !buf_full_q;
  assign wrap     = fall && (bit_cnt_q == CNT_LAST);
  assign cnt_next = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + BW'(1);
  assign in_right = (cnt_next >= SLOT);
  assign pos      = in_right ? cnt_next - SLOT : cnt_next;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    dat_d         = dat_q;
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    buf_full_d    = buf_full_q;
    buf_l_d       = buf_l_q;
    buf_r_d       = buf_r_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    // accept only happens when empty, load only clears when full: the two
    // never touch buf_full in the same cycle, so a write at the load sticks.
    if (accept) begin
      buf_l_d    = sample_L;
      buf_r_d    = sample_R;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = CNT_LAST;
        lrck_d    = 1'b0;
        dat_d     = 1'b0;
        if (enable) state_d = RUN;
      end
      RUN, DRAIN: begin
        state_d = enable ? RUN : DRAIN;
        if (fall) begin
          bit_cnt_d = cnt_next;
          lrck_d    = in_right;
          dat_d     = 1'b0;
          // slot position 0 is the I2S delay bit; 1..WORD_LENGTH carry data
          if (pos != '0 && pos <= WLEN) begin
            if (in_right) begin
              dat_d     = shift_r_q[WORD_LENGTH-1];
              shift_r_d = shift_r_q << 1;
            end else begin
              dat_d     = shift_l_q[WORD_LENGTH-1];
              shift_l_d = shift_l_q << 1;
            end
          end
          if (wrap) begin
            if (state_q == DRAIN && !enable) begin
              state_d   = IDLE;
              bit_cnt_d = CNT_LAST;
            end else begin
              frame_start_d = 1'b1;
              if (buf_full_q) begin
                shift_l_d  = buf_l_q;
                shift_r_d  = buf_r_q;
                buf_full_d = 1'b0;
              end else begin
                shift_l_d  = '0;
                shift_r_d  = '0;
                underrun_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= CNT_LAST;
      lrck_q        <= 1'b0;
      dat_q         <= 1'b0;
      shift_l_q     <= '0;
      shift_r_q     <= '0;
      buf_full_q    <= 1'b0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      dat_q         <= dat_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      buf_full_q    <= buf_full_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ~buf_full_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_dat      = dat_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule
